// File: rtl/sb_pkg.sv
// Shared constants and the entry record for the store buffer.
package sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;
    localparam int SB_DW            = 32;
    localparam int SB_PTR_W         = $clog2(SB_DEPTH_DEFAULT);

    // Address and data widths of a store buffer instance must not exceed these.
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_ptr_ctrl.sv
// Head/tail pointers and occupancy count of the store buffer ring.
module sb_ptr_ctrl
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_req_i,
    input  logic             pop_req_i,
    output logic             push_o,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop;

    // Full is taken from the registered count, so a same-cycle pop never admits a push.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_o  = push_req_i && !full_o;
    assign pop     = pop_req_i && !empty_o;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_o) tail_d = tail_q + 1'b1;
        if (pop)    head_d = head_q + 1'b1;
        case ({push_o, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/store_buffer.sv
// Committed-store buffer: in-order drain to the data cache plus youngest-match load forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          rob_commitmemwrite,
    input  logic [AW-1:0] rob_swaddr,
    input  logic [5:0]    rob_commitcurrphyaddr,
    output logic [5:0]    sb_rf_rdaddr,
    input  logic [DW-1:0] rf_sb_rddata,
    output logic          sb_full,
    output logic          sb_empty,
    output logic          dc_wr_req,
    output logic [AW-1:0] dc_wr_addr,
    output logic [DW-1:0] dc_wr_data,
    input  logic          dc_wr_ack,
    input  logic          ld_chk_valid,
    input  logic [AW-1:0] ld_chk_addr,
    output logic          sb_ld_hit,
    output logic [DW-1:0] sb_ld_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             unused_ld_offset;

    sb_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst_b      (rst_b),
        .push_req_i (rob_commitmemwrite),
        .pop_req_i  (dc_wr_ack),
        .push_o     (push),
        .head_o     (head),
        .tail_o     (tail),
        .count_o    (count),
        .full_o     (sb_full),
        .empty_o    (sb_empty)
    );

    assign sb_rf_rdaddr = rob_commitcurrphyaddr;

    // NOTE: entry storage has no reset; the occupancy count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail] <= '{addr: SB_AW'(rob_swaddr), data: SB_DW'(rf_sb_rddata)};
        end
    end

    assign dc_wr_req  = !sb_empty;
    assign dc_wr_addr = dc_wr_req ? AW'(entries_q[head].addr) : '0;
    assign dc_wr_data = dc_wr_req ? DW'(entries_q[head].data) : '0;

    // Walk occupied entries oldest to youngest; the last match (nearest the tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        sb_ld_hit  = 1'b0;
        sb_ld_data = '0;
        if (ld_chk_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + PTR_W'(k);
                if ((CNT_W'(k) < count) &&
                    (entries_q[idx].addr[AW-1:2] == ld_chk_addr[AW-1:2])) begin
                    sb_ld_hit  = 1'b1;
                    sb_ld_data = DW'(entries_q[idx].data);
                end
            end
        end
    end

    // Forwarding matches on word address; the byte offset is deliberately ignored.
    assign unused_ld_offset = ^ld_chk_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, corner sequences, randomized model check.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_b;
    logic        rob_commitmemwrite;
    logic [31:0] rob_swaddr;
    logic [5:0]  rob_commitcurrphyaddr;
    logic [5:0]  sb_rf_rdaddr;
    logic [31:0] rf_sb_rddata;
    logic        sb_full;
    logic        sb_empty;
    logic        dc_wr_req;
    logic [31:0] dc_wr_addr;
    logic [31:0] dc_wr_data;
    logic        dc_wr_ack;
    logic        ld_chk_valid;
    logic [31:0] ld_chk_addr;
    logic        sb_ld_hit;
    logic [31:0] sb_ld_data;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk                   (clk),
        .rst_b                 (rst_b),
        .rob_commitmemwrite    (rob_commitmemwrite),
        .rob_swaddr            (rob_swaddr),
        .rob_commitcurrphyaddr (rob_commitcurrphyaddr),
        .sb_rf_rdaddr          (sb_rf_rdaddr),
        .rf_sb_rddata          (rf_sb_rddata),
        .sb_full               (sb_full),
        .sb_empty              (sb_empty),
        .dc_wr_req             (dc_wr_req),
        .dc_wr_addr            (dc_wr_addr),
        .dc_wr_data            (dc_wr_data),
        .dc_wr_ack             (dc_wr_ack),
        .ld_chk_valid          (ld_chk_valid),
        .ld_chk_addr           (ld_chk_addr),
        .sb_ld_hit             (sb_ld_hit),
        .sb_ld_data            (sb_ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        logic        commit;
        logic [31:0] sw_addr;
        logic [31:0] sw_data;
        logic        ack;
        logic        ldv;
        logic [31:0] ld_addr;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_full;
        logic        e_empty;
        logic        e_hit;
        logic [31:0] e_ld;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   model_chk = 1'b0;
    rec_t mq[$];
    rec_t exp_wr[$];
    rec_t wr_log[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_fwd(input logic [31:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].addr[31:2] == a[31:2]) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
    endfunction

    // Reference behaviour at a rising edge: a queue that is popped by an ack and pushed if not full.
    task automatic model_edge();
        bit   do_pop;
        bit   do_push;
        rec_t r;
        if (!rst_b) begin
            mq.delete();
            return;
        end
        do_pop  = (mq.size() != 0) && dc_wr_ack;
        do_push = rob_commitmemwrite && (mq.size() < DEPTH);
        if (do_pop) r = mq.pop_front();
        if (do_push) begin
            r.addr = rob_swaddr;
            r.data = rf_sb_rddata;
            mq.push_back(r);
            exp_wr.push_back(r);
        end
    endtask

    task automatic observe();
        logic        h;
        logic [31:0] d;
        rec_t        r;
        if (dc_wr_req && dc_wr_ack) begin
            r.addr = dc_wr_addr;
            r.data = dc_wr_data;
            wr_log.push_back(r);
        end
        if (model_chk) begin
            check("dc_wr_req", dc_wr_req, mq.size() != 0);
            if (mq.size() != 0) begin
                check("dc_wr_addr", dc_wr_addr, mq[0].addr);
                check("dc_wr_data", dc_wr_data, mq[0].data);
            end
            check("sb_full", sb_full, mq.size() == DEPTH);
            check("sb_empty", sb_empty, mq.size() == 0);
            model_fwd(ld_chk_addr, h, d);
            h = h && ld_chk_valid;
            check("sb_ld_hit", sb_ld_hit, h);
            check("sb_ld_data", sb_ld_data, h ? d : 32'h0);
            check("sb_rf_rdaddr", sb_rf_rdaddr, rob_commitcurrphyaddr);
        end
    endtask

    task automatic to_negedge();
        @(negedge clk);
        observe();
    endtask

    task automatic to_posedge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        to_negedge();
        to_posedge();
    endtask

    task automatic set_in(input logic c, input logic [31:0] a, input logic [31:0] d, input logic k);
        rob_commitmemwrite = c;
        rob_swaddr         = a;
        rf_sb_rddata       = d;
        dc_wr_ack          = k;
    endtask

    initial begin
        rec_t        fill[4];
        logic [31:0] bp_data;
        int          base;

        // Vectors from reset: single store, ignored ack, forwarding with youngest-wins and push exclusion.
        vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h40,  32'h11,       1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h42,  32'h22,       1'b0, 1'b1, 32'h40,  1'b1, 32'h40,  32'h11,       1'b0, 1'b0, 1'b1, 32'h11};
        vecs[5]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h40,  1'b1, 32'h40,  32'h11,       1'b0, 1'b0, 1'b1, 32'h22};
        vecs[6]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h80,  1'b1, 32'h40,  32'h11,       1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h40,  1'b1, 32'h40,  32'h11,       1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h43,  1'b1, 32'h40,  32'h11,       1'b0, 1'b0, 1'b1, 32'h22};
        vecs[9]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h41,  1'b1, 32'h40,  32'h11,       1'b0, 1'b0, 1'b1, 32'h22};
        vecs[10] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h40,  1'b1, 32'h42,  32'h22,       1'b0, 1'b0, 1'b1, 32'h22};
        vecs[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h0};

        rst_b                 = 1'b0;
        rob_commitcurrphyaddr = 6'h15;
        ld_chk_valid          = 1'b1;
        ld_chk_addr           = 32'h0;
        set_in(1'b1, 32'h0, 32'h0, 1'b1);
        #3;
        check("reset dc_wr_req", dc_wr_req, 1'b0);
        check("reset sb_empty", sb_empty, 1'b1);
        check("reset sb_full", sb_full, 1'b0);
        check("reset sb_ld_hit", sb_ld_hit, 1'b0);
        check("sb_rf_rdaddr", sb_rf_rdaddr, 6'h15);
        step();
        step();
        rst_b = 1'b1;

        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].commit, vecs[i].sw_addr, vecs[i].sw_data, vecs[i].ack);
            ld_chk_valid = vecs[i].ldv;
            ld_chk_addr  = vecs[i].ld_addr;
            to_negedge();
            check($sformatf("vec%0d dc_wr_req", i), dc_wr_req, vecs[i].e_req);
            if (vecs[i].e_req) begin
                check($sformatf("vec%0d dc_wr_addr", i), dc_wr_addr, vecs[i].e_addr);
                check($sformatf("vec%0d dc_wr_data", i), dc_wr_data, vecs[i].e_data);
            end
            check($sformatf("vec%0d sb_full", i), sb_full, vecs[i].e_full);
            check($sformatf("vec%0d sb_empty", i), sb_empty, vecs[i].e_empty);
            check($sformatf("vec%0d sb_ld_hit", i), sb_ld_hit, vecs[i].e_hit);
            check($sformatf("vec%0d sb_ld_data", i), sb_ld_data, vecs[i].e_ld);
            to_posedge();
        end

        model_chk = 1'b1;
        ld_chk_valid = 1'b0;

        // Fill to full, drop a commit while full, then push+pop while full, then drain in order.
        wr_log.delete();
        for (int i = 0; i < 4; i++) begin
            fill[i].addr = 32'h1000 + 32'(i * 16);
            fill[i].data = $urandom;
            set_in(1'b1, fill[i].addr, fill[i].data, 1'b0);
            step();
        end
        set_in(1'b1, 32'h200, 32'hBAD0_0200, 1'b0);
        to_negedge();
        check("fill sb_full", sb_full, 1'b1);
        to_posedge();
        set_in(1'b1, 32'h300, 32'hBAD0_0300, 1'b1);
        to_negedge();
        check("full after drop", sb_full, 1'b1);
        to_posedge();
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        to_negedge();
        check("no push on pop while full", sb_full, 1'b0);
        to_posedge();
        for (int i = 0; i < 6; i++) step();
        check("fill write count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            check($sformatf("fill write%0d addr", i), wr_log[i].addr, fill[i].addr);
            check($sformatf("fill write%0d data", i), wr_log[i].data, fill[i].data);
        end

        // Backpressure: head must hold while the ack is withheld.
        bp_data = $urandom;
        set_in(1'b1, 32'h500, bp_data, 1'b0);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            to_negedge();
            check($sformatf("bp%0d addr", i), dc_wr_addr, 32'h500);
            check($sformatf("bp%0d data", i), dc_wr_data, bp_data);
            to_posedge();
        end
        dc_wr_ack = 1'b1;
        step();
        dc_wr_ack = 1'b0;

        // Randomized traffic with wrap, push+pop, full stalls and forwarding.
        wr_log.delete();
        exp_wr.delete();
        for (int c = 0; c < 400; c++) begin
            base = $urandom_range(0, 7);
            set_in($urandom_range(0, 1) == 1, 32'h2000 + 32'(base * 4) + 32'($urandom_range(0, 3)),
                   $urandom, $urandom_range(0, 2) == 0);
            ld_chk_valid          = $urandom_range(0, 3) != 0;
            ld_chk_addr           = 32'h2000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
            rob_commitcurrphyaddr = 6'($urandom);
            step();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        for (int c = 0; c < 8; c++) step();
        check("random write count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            if (wr_log[i] != exp_wr[i]) begin
                check($sformatf("random write%0d addr", i), wr_log[i].addr, exp_wr[i].addr);
                check($sformatf("random write%0d data", i), wr_log[i].data, exp_wr[i].data);
            end
        end

        // Reset mid-operation with a request pending.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h3000 + 32'(i * 4), $urandom, 1'b0);
            step();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 32'h3000;
        #1;
        check("pre-reset dc_wr_req", dc_wr_req, 1'b1);
        rst_b = 1'b0;
        mq.delete();
        #1;
        check("async reset dc_wr_req", dc_wr_req, 1'b0);
        check("async reset sb_empty", sb_empty, 1'b1);
        check("async reset sb_ld_hit", sb_ld_hit, 1'b0);
        step();
        rst_b = 1'b1;
        wr_log.delete();
        dc_wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("writes after reset", wr_log.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
